// File: rtl/cplx_alu.sv
// cplx_alu: sequential complex ALU (ADD/SUB/MUL/MAC/CONJ/CLRACC) sharing one
// 32x32 signed multiplier across four cycles, with a start/busy/done handshake.
module cplx_alu #(
   parameter int MUL_STAGES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  opr,
   input  logic [63:0] opA,
   input  logic [63:0] opB,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic        ovf
);
   if (MUL_STAGES != 4) begin : g_bad_stages
      $error("cplx_alu: MUL_STAGES must be 4");
   end
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_MAC = 3'd3;
   localparam logic [2:0] OP_CONJ = 3'd4;
   localparam logic [2:0] OP_CLR = 3'd5;
   typedef enum logic [3:0] {IDLE, EXEC, MUL0, MUL1, MUL2, MUL3, SUM, ACC, DONE} state_t;
   state_t r_st, w_nx;
   logic [63:0] r_a, r_b, r_acc, r_result;
   logic [2:0] r_op;
   logic signed [63:0] r_ac, r_bd, r_ad, r_bc, w_prod;
   logic signed [31:0] w_mx, w_my;
   logic [31:0] r_re, r_im;
   logic r_ovf, r_ovf_o, r_done;
   logic signed [65:0] w_ar, w_ai, w_br, w_bi, w_re, w_im;
   logic w_ovf;
   function automatic logic signed [65:0] sx32(input logic [31:0] v);
      return {{34{v[31]}}, v};
   endfunction
   function automatic logic signed [65:0] sx64(input logic [63:0] v);
      return {{2{v[63]}}, v};
   endfunction
   // exact value fits in 32-bit signed only if bits [65:31] are all equal
   function automatic logic out32(input logic [65:0] v);
      return !(&v[65:31] || ~|v[65:31]);
   endfunction
   assign w_ar = sx32(r_a[63:32]);
   assign w_ai = sx32(r_a[31:0]);
   assign w_br = sx32(r_b[63:32]);
   assign w_bi = sx32(r_b[31:0]);
   // MUL0..MUL3 produce ac, bd, ad, bc on the shared multiplier
   assign w_mx = (r_st == MUL0 || r_st == MUL2) ? r_a[63:32] : r_a[31:0];
   assign w_my = (r_st == MUL0 || r_st == MUL3) ? r_b[63:32] : r_b[31:0];
   assign w_prod = w_mx * w_my;
   always_comb begin
      w_re = '0;
      w_im = '0;
      if (r_st == SUM) begin
         w_re = sx64(r_ac) - sx64(r_bd);
         w_im = sx64(r_ad) + sx64(r_bc);
      end else if (r_st == ACC) begin
         w_re = sx32(r_acc[63:32]) + sx32(r_re);
         w_im = sx32(r_acc[31:0]) + sx32(r_im);
      end else if (r_st == EXEC) begin
         w_re = r_op == OP_ADD ? w_ar + w_br : r_op == OP_SUB ? w_ar - w_br : r_op == OP_CONJ ? w_ar : '0;
         w_im = r_op == OP_ADD ? w_ai + w_bi : r_op == OP_SUB ? w_ai - w_bi : r_op == OP_CONJ ? -w_ai : '0;
      end
   end
   assign w_ovf = out32(w_re) | out32(w_im);
   always_comb begin
      w_nx = r_st;
      case (r_st)
         IDLE: if (start) w_nx = (opr == OP_MUL || opr == OP_MAC) ? MUL0 : EXEC;
         EXEC: w_nx = DONE;
         MUL0: w_nx = MUL1;
         MUL1: w_nx = MUL2;
         MUL2: w_nx = MUL3;
         MUL3: w_nx = SUM;
         SUM:  w_nx = r_op == OP_MAC ? ACC : DONE;
         ACC:  w_nx = DONE;
         default: w_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) r_st <= IDLE;
      else r_st <= w_nx;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
         r_op <= '0;
         r_ac <= '0;
         r_bd <= '0;
         r_ad <= '0;
         r_bc <= '0;
         r_re <= '0;
         r_im <= '0;
         r_ovf <= 1'b0;
         r_acc <= '0;
         r_done <= 1'b0;
         r_result <= '0;
         r_ovf_o <= 1'b0;
      end else begin
         r_done <= r_st == DONE;
         if (r_st == IDLE && start) begin
            r_a <= opA;
            r_b <= opB;
            r_op <= opr;
         end
         if (r_st == MUL0) r_ac <= w_prod;
         if (r_st == MUL1) r_bd <= w_prod;
         if (r_st == MUL2) r_ad <= w_prod;
         if (r_st == MUL3) r_bc <= w_prod;
         if (r_st == EXEC || r_st == SUM || r_st == ACC) begin
            r_re <= w_re[31:0];
            r_im <= w_im[31:0];
            r_ovf <= (r_st == ACC && r_ovf) | w_ovf;
         end
         if (r_st == ACC) r_acc <= {w_re[31:0], w_im[31:0]};
         if (r_st == EXEC && r_op == OP_CLR) r_acc <= '0;
         if (r_st == DONE) begin
            r_result <= {r_re, r_im};
            r_ovf_o <= r_ovf;
         end
      end
   end
   assign busy = r_st != IDLE;
   assign done = r_done;
   assign result = r_result;
   assign ovf = r_ovf_o;
endmodule
